// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan decoder.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;

    // Segment patterns {a,b,c,d,e,f,g}, a = MSB, active-high.
    localparam logic [SEG_W-1:0] SEG_0 = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b1111011;

    // Width of the stability counter; enough for STABLE_CNT up to 15.
    localparam int unsigned CNT_W = 4;

    // StScan: still collecting digits. StPend: a full frame waits behind the output register.
    typedef enum logic {
        StScan = 1'b0,
        StPend = 1'b1
    } collector_state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational segment-pattern to BCD lookup; unknown patterns give 4'hF and an error flag.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] seg_i,
    output logic [3:0]       bcd_o,
    output logic             err_o
);

    // Inverse of the BCD-to-7-segment encoder.
    always_comb begin
        bcd_o = 4'hF;
        err_o = 1'b0;
        case (seg_i)
            SEG_0:   bcd_o = 4'd0;
            SEG_1:   bcd_o = 4'd1;
            SEG_2:   bcd_o = 4'd2;
            SEG_3:   bcd_o = 4'd3;
            SEG_4:   bcd_o = 4'd4;
            SEG_5:   bcd_o = 4'd5;
            SEG_6:   bcd_o = 4'd6;
            SEG_7:   bcd_o = 4'd7;
            SEG_8:   bcd_o = 4'd8;
            SEG_9:   bcd_o = 4'd9;
            default: begin
                bcd_o = 4'hF;
                err_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Captures a multiplexed 7-segment display scan and presents whole decoded frames
// through a valid/ready output register.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned STABLE_CNT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SEG_W-1:0]        seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   err_out,
    output logic                    frame_valid,
    input  logic                    frame_ready
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CNT);

    // Input sample registers and the previous sample used for the stability check
    logic [SEG_W-1:0]        seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [SEG_W-1:0]        prev_seg_q, prev_seg_d;
    logic [NUM_DIGITS-1:0]   prev_sel_q, prev_sel_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    // Per-digit slots and captured bits
    logic [4*NUM_DIGITS-1:0] slot_bcd_q, slot_bcd_d;
    logic [NUM_DIGITS-1:0]   slot_err_q, slot_err_d;
    logic [NUM_DIGITS-1:0]   capt_q, capt_d, capt_upd;

    // Output register
    logic [4*NUM_DIGITS-1:0] bcd_out_q, bcd_out_d;
    logic [NUM_DIGITS-1:0]   err_out_q, err_out_d;
    logic                    frame_valid_q, frame_valid_d;

    collector_state_e        state_q, state_d;

    logic                    sample_ok;
    logic                    same_sample;
    logic                    capture;
    logic                    all_capt;
    logic                    out_free;
    logic                    xfer;
    logic [3:0]              dec_bcd;
    logic                    dec_err;

    seg7_to_bcd u_seg7_to_bcd (
        .seg_i (seg_q),
        .bcd_o (dec_bcd),
        .err_o (dec_err)
    );

    // Sample qualification: exactly one digit strobe, and whether it repeats the last sample
    always_comb begin
        sample_ok   = (sel_q != '0) && ((sel_q & (sel_q - NUM_DIGITS'(1))) == '0);
        same_sample = ({sel_q, seg_q} == {prev_sel_q, prev_seg_q});
        seg_d       = seg_in;
        sel_d       = dig_sel;
        prev_seg_d  = seg_q;
        prev_sel_d  = sel_q;
    end

    // Stability counter; a digit is captured only on the cycle the count first hits the target
    always_comb begin
        cnt_d = '0;
        if (sample_ok) begin
            if (same_sample) begin
                cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
            end else begin
                cnt_d = CNT_W'(1);
            end
        end
        capture = sample_ok && (cnt_d == CntMax) && (cnt_q != CntMax);
    end

    // Merge this cycle's capture into the slots so a completing capture transfers immediately
    always_comb begin
        slot_bcd_d = slot_bcd_q;
        slot_err_d = slot_err_q;
        capt_upd   = capt_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capture && sel_q[i]) begin
                slot_bcd_d[i*4 +: 4] = dec_bcd;
                slot_err_d[i]        = dec_err;
                capt_upd[i]          = 1'b1;
            end
        end
        all_capt = &capt_upd;
        out_free = !frame_valid_q || frame_ready;
    end

    // Collector next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StScan: if (all_capt && !out_free) state_d = StPend;
            StPend: if (frame_ready) state_d = StScan;
        endcase
    end

    // Collector output: when the slots move into the output register
    always_comb begin
        xfer = 1'b0;
        unique case (state_q)
            StScan: xfer = all_capt && out_free;
            StPend: xfer = frame_ready;
        endcase
    end

    // Output register and captured-bit update
    always_comb begin
        capt_d        = xfer ? '0 : capt_upd;
        bcd_out_d     = xfer ? slot_bcd_d : bcd_out_q;
        err_out_d     = xfer ? slot_err_d : err_out_q;
        frame_valid_d = frame_valid_q;
        if (xfer) begin
            frame_valid_d = 1'b1;
        end else if (frame_ready) begin
            frame_valid_d = 1'b0;
        end
    end

    // Collector state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StScan;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q         <= '0;
            sel_q         <= '0;
            prev_seg_q    <= '0;
            prev_sel_q    <= '0;
            cnt_q         <= '0;
            slot_bcd_q    <= '0;
            slot_err_q    <= '0;
            capt_q        <= '0;
            bcd_out_q     <= '0;
            err_out_q     <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            seg_q         <= seg_d;
            sel_q         <= sel_d;
            prev_seg_q    <= prev_seg_d;
            prev_sel_q    <= prev_sel_d;
            cnt_q         <= cnt_d;
            slot_bcd_q    <= slot_bcd_d;
            slot_err_q    <= slot_err_d;
            capt_q        <= capt_d;
            bcd_out_q     <= bcd_out_d;
            err_out_q     <= err_out_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign bcd_out     = bcd_out_q;
    assign err_out     = err_out_q;
    assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus randomized scanning, checked every
// cycle against a frame-level reference model.
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    seg_in = '0;
    logic [ND-1:0] dig_sel = '0;
    logic          frame_ready = 1'b0;
    logic [4*ND-1:0] bcd_out;
    logic [ND-1:0] err_out;
    logic          frame_valid;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    bit rand_rdy = 1'b0;

    seg7_scan_decoder #(
        .NUM_DIGITS (ND),
        .STABLE_CNT (SC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .bcd_out     (bcd_out),
        .err_out     (err_out),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready)
    );

    always #5 clk = ~clk;

    // The existing BCD-to-7-segment encoder the decoder inverts.
    function automatic logic [6:0] bcd_to_7seg(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // {err, nibble}: search the encoder table for the pattern.
    function automatic logic [4:0] model_decode(input logic [6:0] s);
        for (int v = 0; v < 10; v++) begin
            if (bcd_to_7seg(v) == s) return {1'b0, 4'(v)};
        end
        return 5'h1F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [ND-1:0]   m_sel, m_psel;
    logic [6:0]      m_seg, m_pseg;
    int              m_run;
    logic [3:0]      m_slot [ND];
    bit              m_serr [ND];
    bit              m_got  [ND];
    logic [4*ND-1:0] m_bcd;
    logic [ND-1:0]   m_err;
    bit              m_ov;

    task automatic model_reset();
        m_sel = '0; m_psel = '0; m_seg = '0; m_pseg = '0; m_run = 0;
        for (int i = 0; i < ND; i++) begin
            m_slot[i] = '0; m_serr[i] = 1'b0; m_got[i] = 1'b0;
        end
        m_bcd = '0; m_err = '0; m_ov = 1'b0;
    endtask

    task automatic model_step();
        int  old_run;
        bit  cap;
        bit  all;
        bit  free;
        int  d;
        logic [4:0] dec;
        old_run = m_run;
        cap = 1'b0;
        // Run length of identical one-hot samples; anything else breaks the run.
        if ($countones(m_sel) == 1) begin
            if (m_sel == m_psel && m_seg == m_pseg) m_run = (m_run >= SC) ? SC : m_run + 1;
            else m_run = 1;
            cap = (m_run == SC) && (old_run != SC);
        end else begin
            m_run = 0;
        end
        if (cap) begin
            d = $clog2(m_sel);
            dec = model_decode(m_seg);
            m_slot[d] = dec[3:0];
            m_serr[d] = dec[4];
            m_got[d] = 1'b1;
        end
        all = 1'b1;
        for (int i = 0; i < ND; i++) if (!m_got[i]) all = 1'b0;
        free = !m_ov || frame_ready;
        if (all && free) begin
            for (int i = 0; i < ND; i++) begin
                m_bcd[i*4 +: 4] = m_slot[i];
                m_err[i] = m_serr[i];
                m_got[i] = 1'b0;
            end
            m_ov = 1'b1;
        end else if (m_ov && frame_ready) begin
            m_ov = 1'b0;
        end
        m_psel = m_sel; m_pseg = m_seg;
        m_sel = dig_sel; m_seg = seg_in;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("cmp_valid", 32'(frame_valid), 32'(m_ov));
                check("cmp_bcd", 32'(bcd_out), 32'(m_bcd));
                check("cmp_err", 32'(err_out), 32'(m_err));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [ND-1:0] sel, input logic [6:0] seg, input int n);
        repeat (n) begin
            dig_sel = sel;
            seg_in = seg;
            if (rand_rdy) frame_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
    endtask

    task automatic put_digit(input int pos, input int val, input int n);
        drive(ND'(1 << pos), bcd_to_7seg(val), n);
    endtask

    task automatic wait_valid(input int lim, output bit seen);
        dig_sel = '0;
        seg_in = '0;
        seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            if (frame_valid === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
    endtask

    initial begin
        bit seen;
        logic [4*ND-1:0] exp_bcd;
        int r;
        logic [ND-1:0] sel;
        logic [6:0] seg;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(frame_valid), 32'd0);
        check("reset_bcd", 32'(bcd_out), 32'd0);
        check("reset_err", 32'(err_out), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Digits 3,0,2,1 with ready high: one-cycle pulse carrying 16'h1203.
        frame_ready = 1'b1;
        put_digit(0, 3, 3); put_digit(1, 0, 3); put_digit(2, 2, 3); put_digit(3, 1, 3);
        wait_valid(8, seen);
        check("t030_seen", 32'(seen), 32'd1);
        check("t030_bcd", 32'(bcd_out), 32'h1203);
        check("t030_err", 32'(err_out), 32'd0);
        @(negedge clk);
        check("t030_pulse", 32'(frame_valid), 32'd0);

        // Round trip of 0..9 through the encoder.
        for (int f = 0; f < 3; f++) begin
            exp_bcd = '0;
            for (int i = 0; i < ND; i++) begin
                put_digit(i, (f * 4 + i) % 10, 3);
                exp_bcd[i*4 +: 4] = 4'((f * 4 + i) % 10);
            end
            wait_valid(8, seen);
            check("t029_seen", 32'(seen), 32'd1);
            check("t029_bcd", 32'(bcd_out), 32'(exp_bcd));
            check("t029_err", 32'(err_out), 32'd0);
            drive('0, '0, 2);
        end

        // Short hold and multi-hot strobe must not capture.
        put_digit(0, 5, 3); put_digit(2, 4, 3); put_digit(3, 7, 3);
        put_digit(1, 9, 2);
        drive(4'b0011, bcd_to_7seg(8), 5);
        wait_valid(5, seen);
        check("t031_no_frame", 32'(seen), 32'd0);
        put_digit(1, 6, 3);
        wait_valid(8, seen);
        check("t031_seen", 32'(seen), 32'd1);
        check("t031_bcd", 32'(bcd_out), 32'h7465);
        drive('0, '0, 2);

        // Blank pattern on digit 2 decodes as an error.
        put_digit(0, 1, 3); put_digit(1, 2, 3);
        drive(4'b0100, 7'b0000000, 3);
        put_digit(3, 3, 3);
        wait_valid(8, seen);
        check("t032_seen", 32'(seen), 32'd1);
        check("t032_bcd", 32'(bcd_out), 32'h3F21);
        check("t032_err", 32'(err_out), 32'b0100);
        drive('0, '0, 2);

        // Back-pressure: first frame held, second presented after one ready pulse.
        frame_ready = 1'b0;
        put_digit(0, 1, 3); put_digit(1, 2, 3); put_digit(2, 3, 3); put_digit(3, 4, 3);
        wait_valid(8, seen);
        check("t033_first", 32'(bcd_out), 32'h4321);
        put_digit(0, 5, 3); put_digit(1, 6, 3); put_digit(2, 7, 3); put_digit(3, 8, 3);
        drive('0, '0, 3);
        check("t033_hold_valid", 32'(frame_valid), 32'd1);
        check("t033_hold_bcd", 32'(bcd_out), 32'h4321);
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        check("t033_b2b_valid", 32'(frame_valid), 32'd1);
        check("t033_second", 32'(bcd_out), 32'h8765);
        @(negedge clk);
        check("t033_still_valid", 32'(frame_valid), 32'd1);
        frame_ready = 1'b1;
        @(negedge clk);
        check("t033_drained", 32'(frame_valid), 32'd0);

        // Asynchronous reset mid-frame discards partial captures.
        put_digit(0, 9, 3); put_digit(1, 8, 3);
        #2 rst_n = 1'b0;
        #1;
        check("t034_async_bcd", 32'(bcd_out), 32'd0);
        check("t034_async_err", 32'(err_out), 32'd0);
        check("t034_async_valid", 32'(frame_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        put_digit(2, 7, 3); put_digit(3, 6, 3);
        wait_valid(5, seen);
        check("t034_no_frame", 32'(seen), 32'd0);
        put_digit(0, 5, 3); put_digit(1, 4, 3);
        wait_valid(8, seen);
        check("t034_seen", 32'(seen), 32'd1);
        check("t034_bcd", 32'(bcd_out), 32'h6745);
        drive('0, '0, 2);

        // Randomized scanning with random back-pressure.
        rand_rdy = 1'b1;
        for (int k = 0; k < 500; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 80) sel = ND'(1 << $urandom_range(0, ND - 1));
            else if (r < 88) sel = '0;
            else sel = ND'($urandom_range(0, 15));
            r = int'($urandom_range(0, 99));
            if (r < 85) seg = bcd_to_7seg(int'($urandom_range(0, 9)));
            else seg = 7'($urandom);
            drive(sel, seg, int'($urandom_range(1, 5)));
        end
        rand_rdy = 1'b0;
        frame_ready = 1'b1;
        drive('0, '0, 10);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
